multi_project_io_mux: RTL and testbench
=======================================

// Module: multi_project_io_mux
// PURPOSE
//  Parametrised successor to the per-project "active" gating in user_project_wrapper.
//  Arbitrates NUM_PROJECTS wrapped projects onto the shared Caravel IO bank (IO_W pads).
//  Exactly one project drives the pads at a time, selected by one-hot LA "active" bits.
//  Every switch passes through a guard interval with all pads tristated, so two projects
//  never contend and no pad glitches during the handover.
// PARAMETERS
//  NUM_PROJECTS  8   number of project slots (>=2)
//  IO_W          38  pads per project (`MPRJ_IO_PADS)
//  GUARD_CYCLES  4   tristate cycles between projects (>=1)
//  SEL_W         $clog2(NUM_PROJECTS), localparam
// PORTS
//  wb_clk_i     in   1                 system clock
//  wb_rst_i     in   1                 async reset, active-high
//  active_i     in   NUM_PROJECTS      raw request, one-hot; from la_data_in (async domain)
//  proj_io_out  in   NUM_PROJECTS*IO_W project p occupies bits [p*IO_W +: IO_W]
//  proj_io_oeb  in   NUM_PROJECTS*IO_W same packing as proj_io_out
//  io_out       out  IO_W              to pads
//  io_oeb       out  IO_W              to pads; 1 = input/tristate
//  active_o     out  NUM_PROJECTS      one-hot enable to the projects
//  cur_sel      out  SEL_W             index of the driving project; valid while running
//  running      out  1                 a project currently owns the pads
//  busy         out  1                 guard interval in progress
//  err          out  1                 synced request is multi-hot
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; io_out=0, io_oeb=all 1, active_o=0,
//    cur_sel=0, running=0, busy=0, err=0; sync flops and counter cleared.
//  - active_i goes through a 2-FF synchroniser -> req. Decode:
//    ZERO (req==0), ONEHOT(k), MULTI (>1 bit set).
//  - FSM states:
//    IDLE  : no owner. ONEHOT(k) -> DRAIN, tgt=k. ZERO/MULTI -> stay.
//    DRAIN : tristated. cnt counts down from GUARD_CYCLES-1.
//            At cnt==0: tgt valid -> RUN, cur_sel=tgt; tgt==none -> IDLE.
//    RUN   : owner cur_sel. ONEHOT(k), k!=cur_sel -> DRAIN, tgt=k.
//            ZERO -> DRAIN, tgt=none. MULTI or same k -> stay.
//  - DRAIN retarget: a new valid decode (ONEHOT differing from tgt, or ZERO) updates tgt
//    and reloads cnt (guard restarts). MULTI is ignored.
//  - All outputs are registered and reflect the state entered on that edge.
//    RUN:        io_out/io_oeb = proj_io_out/oeb slice[cur_sel] (one-cycle register delay);
//                active_o = 1<<cur_sel; running=1.
//    IDLE/DRAIN: io_out=0, io_oeb=all 1, active_o=0, running=0; busy=1 only in DRAIN.
//  - Latency: active_i edge -> DRAIN entered after 3 clk (2 sync + 1 FSM).
//    First driven pad cycle GUARD_CYCLES clk after that.
//  - err = registered (state of req == MULTI); clears once req is no longer multi-hot.
//  - Indices >= NUM_PROJECTS cannot be reached (one-hot width == NUM_PROJECTS).
//  - Reset mid-DRAIN/RUN: pads tristate immediately (async), independent of the clock.
// STRUCTURE
//  - mpw_mux_pkg: typedef enum {IDLE, DRAIN, RUN} mux_state_t; function onehot2idx;
//    decode constants REQ_ZERO/REQ_ONEHOT/REQ_MULTI.
//  - Sub-module sync_2ff #(W): async active-high reset, reused for active_i.
//  - Top: decoder, FSM + guard counter, output mux/registers.
// TESTING
//  1. Reset with active_i=0 -> io_oeb=all 1, active_o=0, running=0 for 20 clk.
//  2. GUARD=4, active_i=8'h04 -> busy at clk 3, running at clk 7;
//     io_out == proj slot 2 one clk later; cur_sel=2.
//  3. RUN slot 2, active_i=8'h10 -> active_o=0 and io_oeb=all 1 for exactly 4 clk,
//     then slot 4 drives; slots 2 and 4 are never both enabled.
//  4. RUN slot 1, active_i=8'h06 -> err=1 after 3 clk, slot 1 keeps driving;
//     active_i=8'h02 -> err=0, no switch.
//  5. Mid-DRAIN retarget 8'h01->8'h80 at cnt==1 -> guard restarts (4 clk), ends RUN slot 7;
//     active_i=0 -> DRAIN -> IDLE.
//  6. Assert wb_rst_i asynchronously mid-RUN -> io_oeb all 1 before the next edge;
//     after release the FSM re-acquires the current request via the full DRAIN.

Source files
------------

// File: rtl/mpw_mux_pkg.sv
// Shared types and helpers for the multi-project IO mux.
package mpw_mux_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, RUN} mux_state_t;

  typedef enum logic [1:0] {REQ_ZERO, REQ_ONEHOT, REQ_MULTI} req_dec_t;

  // Widest request vector the index helper handles.
  localparam int MAX_PROJ  = 32;
  localparam int MAX_SEL_W = 5;

  function automatic logic [MAX_SEL_W-1:0] onehot2idx(input logic [MAX_PROJ-1:0] v);
    logic [MAX_SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PROJ; i++) begin
      if (v[i]) idx |= MAX_SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static control bits from another clock domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/multi_project_io_mux.sv
// Hands the shared IO bank to one project at a time, with a tristated guard
// interval on every handover so two projects never drive the pads together.
module multi_project_io_mux
  import mpw_mux_pkg::*;
#(
  parameter int NUM_PROJECTS = 8,
  parameter int IO_W         = 38,
  parameter int GUARD_CYCLES = 4,
  localparam int SEL_W       = $clog2(NUM_PROJECTS)
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_PROJECTS-1:0]      active_i,
  input  logic [NUM_PROJECTS*IO_W-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_W-1:0] proj_io_oeb,
  output logic [IO_W-1:0]              io_out,
  output logic [IO_W-1:0]              io_oeb,
  output logic [NUM_PROJECTS-1:0]      active_o,
  output logic [SEL_W-1:0]             cur_sel,
  output logic                         running,
  output logic                         busy,
  output logic                         err
);

  localparam int            CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  logic [NUM_PROJECTS-1:0] w_req;
  req_dec_t                w_dec;
  logic [SEL_W-1:0]        w_idx;

  mux_state_t       r_state, w_nxt_state;
  logic [SEL_W-1:0] r_tgt, w_nxt_tgt;
  logic             r_tgt_vld, w_nxt_tgt_vld;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [SEL_W-1:0] r_cur_sel, w_nxt_sel;
  logic             r_err;

  sync_2ff #(.W(NUM_PROJECTS)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (active_i),
    .q   (w_req)
  );

  always_comb begin
    w_dec = REQ_MULTI;
    if (w_req == '0)                 w_dec = REQ_ZERO;
    else if ($countones(w_req) == 1) w_dec = REQ_ONEHOT;
    w_idx = SEL_W'(onehot2idx(MAX_PROJ'(w_req)));
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_tgt     = r_tgt;
    w_nxt_tgt_vld = r_tgt_vld;
    w_nxt_cnt     = r_cnt;
    w_nxt_sel     = r_cur_sel;
    case (r_state)
      IDLE: begin
        if (w_dec == REQ_ONEHOT) begin
          w_nxt_state   = DRAIN;
          w_nxt_tgt     = w_idx;
          w_nxt_tgt_vld = 1'b1;
          w_nxt_cnt     = GUARD_LOAD;
        end
      end
      DRAIN: begin
        // A changed request restarts the guard rather than cutting it short.
        if ((w_dec == REQ_ONEHOT && (!r_tgt_vld || w_idx != r_tgt)) ||
            (w_dec == REQ_ZERO && r_tgt_vld)) begin
          w_nxt_tgt     = w_idx;
          w_nxt_tgt_vld = (w_dec == REQ_ONEHOT);
          w_nxt_cnt     = GUARD_LOAD;
        end else if (r_cnt == '0) begin
          if (r_tgt_vld) begin
            w_nxt_state = RUN;
            w_nxt_sel   = r_tgt;
          end else begin
            w_nxt_state = IDLE;
          end
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      RUN: begin
        if ((w_dec == REQ_ONEHOT && w_idx != r_cur_sel) || w_dec == REQ_ZERO) begin
          w_nxt_state   = DRAIN;
          w_nxt_tgt     = w_idx;
          w_nxt_tgt_vld = (w_dec == REQ_ONEHOT);
          w_nxt_cnt     = GUARD_LOAD;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_tgt     <= '0;
      r_tgt_vld <= 1'b0;
      r_cnt     <= '0;
      r_cur_sel <= '0;
      r_err     <= 1'b0;
      io_out    <= '0;
      io_oeb    <= '1;
      active_o  <= '0;
      running   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_tgt     <= w_nxt_tgt;
      r_tgt_vld <= w_nxt_tgt_vld;
      r_cnt     <= w_nxt_cnt;
      r_cur_sel <= w_nxt_sel;
      r_err     <= (w_dec == REQ_MULTI);
      running   <= (w_nxt_state == RUN);
      busy      <= (w_nxt_state == DRAIN);
      // Pad outputs follow the state being entered, not the one being left.
      if (w_nxt_state == RUN) begin
        io_out   <= proj_io_out[w_nxt_sel*IO_W +: IO_W];
        io_oeb   <= proj_io_oeb[w_nxt_sel*IO_W +: IO_W];
        active_o <= NUM_PROJECTS'(1) << w_nxt_sel;
      end else begin
        io_out   <= '0;
        io_oeb   <= '1;
        active_o <= '0;
      end
    end
  end

  assign cur_sel = r_cur_sel;
  assign err     = r_err;

endmodule

// File: tb/tb_multi_project_io_mux.sv
// Directed plus randomized bench for multi_project_io_mux against a cycle-level reference model.
module tb_multi_project_io_mux;

  localparam int NP    = 8;
  localparam int IO_W  = 38;
  localparam int GUARD = 4;
  localparam int SEL_W = $clog2(NP);

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      active_i;
  logic [NP*IO_W-1:0] proj_io_out;
  logic [NP*IO_W-1:0] proj_io_oeb;
  logic [IO_W-1:0]    io_out;
  logic [IO_W-1:0]    io_oeb;
  logic [NP-1:0]      active_o;
  logic [SEL_W-1:0]   cur_sel;
  logic               running;
  logic               busy;
  logic               err;

  int checks = 0;
  int errors = 0;

  // Reference model: request delay line, current owner, pending target, guard cycles left.
  logic [NP-1:0]      req_q[$];
  int                 owner;
  int                 pending;
  int                 guard_left;
  bit                 exp_err;
  logic [NP*IO_W-1:0] cap_out;
  logic [NP*IO_W-1:0] cap_oeb;

  multi_project_io_mux #(
    .NUM_PROJECTS (NP),
    .IO_W         (IO_W),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .active_i    (active_i),
    .proj_io_out (proj_io_out),
    .proj_io_oeb (proj_io_oeb),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .active_o    (active_o),
    .cur_sel     (cur_sel),
    .running     (running),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    req_q      = '{};
    req_q.push_back('0);
    req_q.push_back('0);
    owner      = -1;
    pending    = -1;
    guard_left = 0;
    exp_err    = 1'b0;
  endtask

  task automatic model_edge(input logic [NP-1:0] a, input logic r);
    logic [NP-1:0] req;
    int n;
    int k;
    if (r) begin
      model_reset();
      return;
    end
    req = req_q.pop_front();
    req_q.push_back(a);
    n = 0;
    k = -1;
    for (int i = 0; i < NP; i++) if (req[i]) begin n++; k = i; end
    exp_err = (n > 1);
    if (guard_left > 0) begin
      if ((n == 1 && k != pending) || (n == 0 && pending >= 0)) begin
        pending    = (n == 1) ? k : -1;
        guard_left = GUARD;
      end else begin
        guard_left--;
        if (guard_left == 0) owner = pending;
      end
    end else if (owner < 0) begin
      if (n == 1) begin
        pending    = k;
        guard_left = GUARD;
      end
    end else if ((n == 1 && k != owner) || n == 0) begin
      pending    = (n == 1) ? k : -1;
      owner      = -1;
      guard_left = GUARD;
    end
  endtask

  task automatic check_outputs();
    bit run;
    run = (owner >= 0) && (guard_left == 0);
    chk("running", 64'(running), 64'(run));
    chk("busy", 64'(busy), 64'(guard_left > 0));
    chk("err", 64'(err), 64'(exp_err));
    chk("active_o", 64'(active_o), run ? 64'(1) << owner : 64'd0);
    chk("io_out", 64'(io_out), run ? 64'(cap_out[owner*IO_W +: IO_W]) : 64'd0);
    chk("io_oeb", 64'(io_oeb), run ? 64'(cap_oeb[owner*IO_W +: IO_W]) : 64'(IO_W'('1)));
    chk("onehot_safe", 64'($countones(active_o) <= 1), 64'd1);
    if (run) chk("cur_sel", 64'(cur_sel), 64'(owner));
  endtask

  task automatic new_proj_data();
    for (int p = 0; p < NP; p++) begin
      proj_io_out[p*IO_W +: IO_W] = IO_W'({$urandom(), $urandom()});
      proj_io_oeb[p*IO_W +: IO_W] = IO_W'({$urandom(), $urandom()});
    end
  endtask

  // One clock: capture pre-edge inputs, advance model, check after edge, re-drive at negedge.
  task automatic tick();
    logic [NP-1:0] a;
    logic          r;
    a       = active_i;
    r       = rst;
    cap_out = proj_io_out;
    cap_oeb = proj_io_oeb;
    @(posedge clk);
    model_edge(a, r);
    #1;
    check_outputs();
    @(negedge clk);
    new_proj_data();
  endtask

  initial begin
    int cnt;
    int seen;
    rst      = 1'b1;
    active_i = '0;
    new_proj_data();
    model_reset();
    #1;
    chk("reset_cur_sel", 64'(cur_sel), 64'd0);
    check_outputs();
    tick();
    tick();
    rst = 1'b0;

    // Idle with no request.
    for (int i = 0; i < 20; i++) tick();

    // First acquisition of slot 2.
    active_i = 8'h04;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) chk("t2_busy_early", 64'(busy), 64'd0);
      if (i == 3) chk("t2_busy_clk3", 64'(busy), 64'd1);
      if (i == 6) chk("t2_run_early", 64'(running), 64'd0);
      if (i == 7) begin
        chk("t2_run_clk7", 64'(running), 64'd1);
        chk("t2_sel", 64'(cur_sel), 64'd2);
      end
      if (i == 8) chk("t2_io_slot2", 64'(io_out), 64'(cap_out[2*IO_W +: IO_W]));
    end

    // Handover 2 -> 4: count tristated cycles.
    active_i = 8'h10;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (active_o == '0) cnt++;
    end
    chk("t3_guard_len", 64'(cnt), 64'(GUARD));
    chk("t3_sel", 64'(cur_sel), 64'd4);

    // Multi-hot request keeps current owner and raises err.
    active_i = 8'h02;
    for (int i = 0; i < 12; i++) tick();
    active_i = 8'h06;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_keep", 64'({running, active_o}), 64'({1'b1, 8'h02}));
    active_i = 8'h02;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_err_clr", 64'(err), 64'd0);
    chk("t4_no_switch", 64'(cur_sel), 64'd1);

    // Retarget mid-guard restarts the guard interval.
    active_i = 8'h01;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (busy) seen = 1;
    end
    chk("t5_drain_seen", 64'(seen), 64'd1);
    active_i = 8'h80;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      cnt++;
      if (running) seen = 1;
    end
    chk("t5_restart_len", 64'(cnt), 64'(GUARD + 3));
    chk("t5_sel", 64'(cur_sel), 64'd7);
    active_i = 8'h00;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_idle", 64'({running, busy}), 64'd0);

    // Asynchronous reset mid-RUN.
    active_i = 8'h08;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_pre_run", 64'(running), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_oeb", 64'(io_oeb), 64'(IO_W'('1)));
    chk("t6_async_act", 64'(active_o), 64'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t6_reacquire", 64'({running, cur_sel}), 64'({1'b1, 3'd3}));

    // Randomized request sequences.
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 3))
        0:       active_i = '0;
        1, 2:    active_i = NP'(1) << $urandom_range(0, NP - 1);
        default: active_i = NP'($urandom());
      endcase
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
